// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for the program loader.
// The master side is the byte source; the slave side is the loader itself.
interface imem_loader_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28
);
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   write_enable;
    logic [ADDR_WIDTH-1:0]  write_address;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   cpu_reset;
    logic                   done;
    logic                   error;

    modport master (
        output byte_valid, byte_data,
        input  write_enable, write_address, instruction, cpu_reset, done, error
    );

    modport slave (
        input  byte_valid, byte_data,
        output write_enable, write_address, instruction, cpu_reset, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Framed program loader: SYNC, N (16 bit), N x 4 instruction bytes, XOR checksum.
// Writes each word into instruction memory and releases the CPU only after a valid frame.
module imem_loader #(
    parameter int          ADDR_WIDTH  = 16,
    parameter int          INSTR_WIDTH = 28,
    parameter int          MAX_WORDS   = 256,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        WORD,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [15:0] word_count;
    logic [15:0] len;
    logic [19:0] word_buf;
    logic [7:0]  csum;
    logic [15:0] frame_len;
    logic [15:0] next_count;

    assign frame_len  = {len[15:8], bus.byte_data};
    assign next_count = word_count + 16'd1;

    // Byte 0 contributes only its low nibble; the upper nibble must be zero on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            byte_idx          <= 2'd0;
            word_count        <= 16'd0;
            len               <= 16'd0;
            word_buf          <= 20'd0;
            csum              <= 8'd0;
            bus.write_enable  <= 1'b0;
            bus.write_address <= '0;
            bus.instruction   <= '0;
            bus.cpu_reset     <= 1'b1;
            bus.done          <= 1'b0;
            bus.error         <= 1'b0;
        end else begin
            bus.write_enable <= 1'b0;
            if (bus.byte_valid) begin
                case (state)
                    IDLE, DONE, ERROR: begin
                        if (bus.byte_data == SYNC_BYTE) begin
                            state             <= LEN_HI;
                            word_count        <= 16'd0;
                            bus.write_address <= '0;
                            csum              <= 8'd0;
                            bus.cpu_reset     <= 1'b1;
                            bus.done          <= 1'b0;
                            bus.error         <= 1'b0;
                        end
                    end
                    LEN_HI: begin
                        len[15:8] <= bus.byte_data;
                        csum      <= csum ^ bus.byte_data;
                        state     <= LEN_LO;
                    end
                    LEN_LO: begin
                        len[7:0] <= bus.byte_data;
                        csum     <= csum ^ bus.byte_data;
                        byte_idx <= 2'd0;
                        if (frame_len > 16'(MAX_WORDS)) begin
                            state     <= ERROR;
                            bus.error <= 1'b1;
                        end else if (frame_len == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= WORD;
                        end
                    end
                    WORD: begin
                        csum     <= csum ^ bus.byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: begin
                                if (bus.byte_data[7:4] != 4'h0) begin
                                    state     <= ERROR;
                                    bus.error <= 1'b1;
                                end
                                word_buf <= {16'h0000, bus.byte_data[3:0]};
                            end
                            2'd3: begin
                                bus.instruction   <= INSTR_WIDTH'({word_buf, bus.byte_data});
                                bus.write_address <= ADDR_WIDTH'(word_count);
                                bus.write_enable  <= 1'b1;
                                word_count        <= next_count;
                                if (next_count == len) begin
                                    state <= CSUM;
                                end
                            end
                            default: word_buf <= {word_buf[11:0], bus.byte_data};
                        endcase
                    end
                    CSUM: begin
                        if (bus.byte_data == csum) begin
                            state         <= DONE;
                            bus.done      <= 1'b1;
                            bus.cpu_reset <= 1'b0;
                        end else begin
                            state     <= ERROR;
                            bus.error <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
